rts_multichain_ctrl: RTL and testbench
======================================

# rts_multichain_ctrl

Parametrised successor to the single-chain random-test-socket (RTS) BIST controller. It sequences PRPG, per-chain SRSG, per-chain SISA and MISR enables across up to NUM_CHAINS scan chains, with shift length, round count and chain selection programmable at run time. A start/busy/done handshake replaces reset-triggered operation. An optional on-chip golden-signature comparator removes the need for a bench-side compare.

## Interface
- SHIFT_W, 8: width of the shift-count operand.
- ROUND_W, 16: width of the round-count operand.
- NUM_CHAINS, 4: number of scan chains (at least 1).
- SIG_W, 16: signature width; used only with RTS_SIG_COMPARE_EN.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a test session; sampled only in IDLE.
- shiftCnt  in  SHIFT_W  scan shift cycles per round; latched at start.
- numRounds  in  ROUND_W  shift/capture rounds; latched at start.
- chainMask  in  NUM_CHAINS  per-chain enable; latched at start.
- NbarT  out  1  1 = shift (test) mode, 0 = normal/capture.
- internalRst  out  1  one-cycle reset pulse to PRPG/SRSG/SISA/MISR/DUT.
- PRPG_En  out  1  advance PRPG.
- MISR_En  out  1  compact primary outputs.
- SRSG_En  out  NUM_CHAINS  per-chain scan-in generator enable.
- SISA_En  out  NUM_CHAINS  per-chain scan-out compactor enable.
- busy  out  1  session in progress (INIT through UNLOAD).
- done  out  1  one-cycle completion pulse.
- roundIdx  out  ROUND_W  index of the current round, 0-based.
- sigIn, goldenSig  in  SIG_W  measured and expected signature (macro only).
- pass, fail  out  1  comparison result (macro only).

## Operation
- States: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE: all outputs 0. start=1 latches the operands and moves to INIT.
- INIT: lasts one cycle with internalRst=1. Moves to SHIFT, or to DONE if the latched numRounds=0.
- SHIFT: NbarT=1. SRSG_En[i] and SISA_En[i] equal latched chainMask[i]. Lasts S cycles, then moves to CAPTURE.
- CAPTURE: lasts one cycle with NbarT=0, PRPG_En=1, MISR_En=1. roundIdx then increments.
  - If roundIdx+1 < R, move to SHIFT.
  - Otherwise move to UNLOAD.
- UNLOAD: S cycles, same as SHIFT but SRSG_En=0. SISA_En still follows the mask so the last capture is compacted. Then moves to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Effective shift length S = max(latched shiftCnt, 1); shiftCnt=0 behaves as 1.
- chainMask=0: timing is unchanged and all per-chain enables stay 0.
- start while busy: ignored. Operand changes mid-session: ignored.
- Shift counter is SHIFT_W bits and round counter is ROUND_W bits; neither wraps, because terminal compare happens before overflow.
- rst at any cycle: next state IDLE. All outputs, counters and roundIdx return to 0, including pass/fail. A session in progress is abandoned and no done pulse is produced.

## Timing
- start=1 at edge k puts the controller in INIT during cycle k+1.
- done is high during cycle k+2+R·(S+1)+S for R≥1, and during cycle k+2 for R=0.
- Example: S=5, R=200 gives done at k+1207.
- All outputs are registered or decoded from registered state; no combinational path runs from inputs to outputs.
- done and busy are never both 1.
- start held high continuously: a new session starts on the cycle after DONE, because IDLE samples it.

## Configuration
- RTS_SIG_COMPARE_EN defined:
  - sigIn, goldenSig, pass and fail exist.
  - In the DONE cycle, pass <= (sigIn==goldenSig) and fail <= !(sigIn==goldenSig).
  - Both hold their values until the next accepted start or rst clears them.
- Undefined: those four ports and the comparison logic are absent. All other behaviour is identical.

## Test plan
- shiftCnt=5, numRounds=3, chainMask=4'b1111, start at edge 0:
  - internalRst is high in cycle 1.
  - CAPTURE falls in cycles 7, 13 and 19.
  - UNLOAD runs cycles 20-24, and done is high in cycle 25.
  - PRPG_En count = 3; total SISA_En-high cycles per chain = 20.
- chainMask=4'b0101, shiftCnt=2, numRounds=2:
  - Chains 1 and 3 never enable; chains 0 and 2 behave as above.
  - UNLOAD SRSG_En=0 on all chains.
- numRounds=0 → INIT in cycle 1, done in cycle 2, no PRPG_En/MISR_En. Also shiftCnt=0, numRounds=1 → done in cycle 5 (S=1).
- rst asserted at cycle 10 of a 200-round session → all outputs 0 at cycle 11, no done pulse. A restart then produces the correct full timing.
- start pulsed again during busy → no effect; done occurs at the originally computed cycle.
- With RTS_SIG_COMPARE_EN:
  - sigIn=goldenSig=16'hA5A5 at DONE → pass=1, fail=0, held until the next start.
  - sigIn=16'hA5A4 → pass=0, fail=1.

Source files
------------

// File: rtl/rts_multichain_ctrl_if.sv
// Operand/handshake bundle for rts_multichain_ctrl.
// The signature compare signals exist only when RTS_SIG_COMPARE_EN is defined.
interface rts_multichain_ctrl_if #(
  parameter int SHIFT_W    = 8,
  parameter int ROUND_W    = 16,
  parameter int NUM_CHAINS = 4,
  parameter int SIG_W      = 16
);
  logic                  start;
  logic [SHIFT_W-1:0]    shiftCnt;
  logic [ROUND_W-1:0]    numRounds;
  logic [NUM_CHAINS-1:0] chainMask;
  logic                  NbarT;
  logic                  internalRst;
  logic                  PRPG_En;
  logic                  MISR_En;
  logic [NUM_CHAINS-1:0] SRSG_En;
  logic [NUM_CHAINS-1:0] SISA_En;
  logic                  busy;
  logic                  done;
  logic [ROUND_W-1:0]    roundIdx;
`ifdef RTS_SIG_COMPARE_EN
  logic [SIG_W-1:0]      sigIn;
  logic [SIG_W-1:0]      goldenSig;
  logic                  pass;
  logic                  fail;

  modport master (
    output start, shiftCnt, numRounds, chainMask, sigIn, goldenSig,
    input  NbarT, internalRst, PRPG_En, MISR_En, SRSG_En, SISA_En,
    input  busy, done, roundIdx, pass, fail
  );
  modport slave (
    input  start, shiftCnt, numRounds, chainMask, sigIn, goldenSig,
    output NbarT, internalRst, PRPG_En, MISR_En, SRSG_En, SISA_En,
    output busy, done, roundIdx, pass, fail
  );
`else
  modport master (
    output start, shiftCnt, numRounds, chainMask,
    input  NbarT, internalRst, PRPG_En, MISR_En, SRSG_En, SISA_En,
    input  busy, done, roundIdx
  );
  modport slave (
    input  start, shiftCnt, numRounds, chainMask,
    output NbarT, internalRst, PRPG_En, MISR_En, SRSG_En, SISA_En,
    output busy, done, roundIdx
  );
`endif
endinterface

// File: rtl/rts_multichain_ctrl.sv
// Multi-chain RTS BIST sequencer with start/busy/done handshake.
// Define RTS_SIG_COMPARE_EN to add the on-chip golden-signature comparator.
module rts_multichain_ctrl #(
  parameter int SHIFT_W    = 8,
  parameter int ROUND_W    = 16,
  parameter int NUM_CHAINS = 4,
  parameter int SIG_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rts_multichain_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [SHIFT_W-1:0]    s_last_q, s_last_d;
  logic [SHIFT_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic [ROUND_W-1:0]    rounds_q, rounds_d;
  logic [ROUND_W-1:0]    round_idx_q, round_idx_d;
  logic [NUM_CHAINS-1:0] mask_q, mask_d;
  logic                  accept_s, shift_last_s, round_last_s;

  logic                  nbar_t_s, internal_rst_s, prpg_en_s, misr_en_s, busy_s, done_s;
  logic [NUM_CHAINS-1:0] srsg_en_s, sisa_en_s;

  assign accept_s     = (state_q == IDLE) && bus.start;
  assign shift_last_s = (shift_cnt_q == s_last_q);
  // CAPTURE is only reachable with rounds_q >= 1, so the decrement never wraps.
  assign round_last_s = (round_idx_q == (rounds_q - ROUND_W'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)               state_d = INIT;    else state_d = IDLE;
      INIT:    if (rounds_q == ROUND_W'(0)) state_d = DONE;    else state_d = SHIFT;
      SHIFT:   if (shift_last_s)            state_d = CAPTURE; else state_d = SHIFT;
      CAPTURE: if (round_last_s)            state_d = UNLOAD;  else state_d = SHIFT;
      UNLOAD:  if (shift_last_s)            state_d = DONE;    else state_d = UNLOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latches and shift/round counters.
  always_comb begin
    s_last_d    = s_last_q;
    rounds_d    = rounds_q;
    mask_d      = mask_q;
    shift_cnt_d = SHIFT_W'(0);
    round_idx_d = round_idx_q;
    if (accept_s) begin
      // Store S-1 so a zero shift count behaves as a single shift cycle.
      s_last_d = (bus.shiftCnt == SHIFT_W'(0)) ? SHIFT_W'(0) : (bus.shiftCnt - SHIFT_W'(1));
      rounds_d = bus.numRounds;
      mask_d   = bus.chainMask;
    end else begin
      s_last_d = s_last_q;
      rounds_d = rounds_q;
      mask_d   = mask_q;
    end
    if (((state_q == SHIFT) || (state_q == UNLOAD)) && !shift_last_s) begin
      shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
    end else begin
      shift_cnt_d = SHIFT_W'(0);
    end
    case (state_q)
      CAPTURE:    round_idx_d = round_idx_q + ROUND_W'(1);
      IDLE, DONE: round_idx_d = ROUND_W'(0);
      default:    round_idx_d = round_idx_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_last_q    <= SHIFT_W'(0);
      rounds_q    <= ROUND_W'(0);
      mask_q      <= {NUM_CHAINS{1'b0}};
      shift_cnt_q <= SHIFT_W'(0);
      round_idx_q <= ROUND_W'(0);
    end else begin
      s_last_q    <= s_last_d;
      rounds_q    <= rounds_d;
      mask_q      <= mask_d;
      shift_cnt_q <= shift_cnt_d;
      round_idx_q <= round_idx_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    nbar_t_s       = 1'b0;
    internal_rst_s = 1'b0;
    prpg_en_s      = 1'b0;
    misr_en_s      = 1'b0;
    busy_s         = 1'b0;
    done_s         = 1'b0;
    srsg_en_s      = {NUM_CHAINS{1'b0}};
    sisa_en_s      = {NUM_CHAINS{1'b0}};
    case (state_q)
      INIT: begin
        internal_rst_s = 1'b1;
        busy_s         = 1'b1;
      end
      SHIFT: begin
        nbar_t_s  = 1'b1;
        srsg_en_s = mask_q;
        sisa_en_s = mask_q;
        busy_s    = 1'b1;
      end
      CAPTURE: begin
        prpg_en_s = 1'b1;
        misr_en_s = 1'b1;
        busy_s    = 1'b1;
      end
      UNLOAD: begin
        nbar_t_s  = 1'b1;
        sisa_en_s = mask_q;
        busy_s    = 1'b1;
      end
      DONE:    done_s   = 1'b1;
      default: nbar_t_s = 1'b0;
    endcase
  end

  assign bus.NbarT       = nbar_t_s;
  assign bus.internalRst = internal_rst_s;
  assign bus.PRPG_En     = prpg_en_s;
  assign bus.MISR_En     = misr_en_s;
  assign bus.SRSG_En     = srsg_en_s;
  assign bus.SISA_En     = sisa_en_s;
  assign bus.busy        = busy_s;
  assign bus.done        = done_s;
  assign bus.roundIdx    = round_idx_q;

`ifdef RTS_SIG_COMPARE_EN
  logic pass_q, pass_d, fail_q, fail_d;

  // Verdict is taken in DONE and held until the next accepted start.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (state_q == DONE) begin
      pass_d = (bus.sigIn == bus.goldenSig);
      fail_d = (bus.sigIn != bus.goldenSig);
    end else if (accept_s) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else begin
      pass_d = pass_q;
      fail_d = fail_q;
    end
  end

  // Verdict registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign bus.pass = pass_q;
  assign bus.fail = fail_q;
`endif

endmodule

// File: tb/tb_rts_multichain_ctrl.sv
// Directed self-checking bench for rts_multichain_ctrl (cycle 1 = first cycle after the start edge).
module tb_rts_multichain_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   prpg_cnt, misr_cnt, done_cnt, done_cyc;
  int   sisa_cnt[4];
  int   srsg_cnt[4];
  int   caps[$];

  rts_multichain_ctrl_if #(.SHIFT_W(8), .ROUND_W(16), .NUM_CHAINS(4), .SIG_W(16)) bus ();

  rts_multichain_ctrl #(.SHIFT_W(8), .ROUND_W(16), .NUM_CHAINS(4), .SIG_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] obs_vec();
    return {bus.NbarT, bus.internalRst, bus.PRPG_En, bus.MISR_En,
            bus.SRSG_En, bus.SISA_En, bus.busy, bus.done};
  endfunction

  // 0 idle, 1 init, 2 shift, 3 capture, 4 unload, 5 done
  function automatic int phase_of(int c, int s, int r);
    int t;
    if (c == 1) return 1;
    t = c - 2;
    if (r == 0) return (t == 0) ? 5 : 0;
    if (t < r * (s + 1)) return ((t % (s + 1)) < s) ? 2 : 3;
    t = t - r * (s + 1);
    if (t < s) return 4;
    if (t == s) return 5;
    return 0;
  endfunction

  function automatic logic [13:0] exp_vec(int ph, logic [3:0] m);
    logic [13:0] v;
    v = {(ph == 2 || ph == 4), (ph == 1), (ph == 3), (ph == 3),
         (ph == 2) ? m : 4'b0000,
         (ph == 2 || ph == 4) ? m : 4'b0000,
         (ph >= 1 && ph <= 4), (ph == 5)};
    return v;
  endfunction

  task automatic run(input int sh, input int r, input logic [3:0] m, input int extra_c);
    int s, ph, ncyc;
    s    = (sh == 0) ? 1 : sh;
    ncyc = ((r == 0) ? 2 : (2 + r * (s + 1) + s)) + 1;
    prpg_cnt = 0; misr_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      sisa_cnt[i] = 0;
      srsg_cnt[i] = 0;
    end
    caps.delete();
    bus.shiftCnt  = 8'(sh);
    bus.numRounds = 16'(r);
    bus.chainMask = m;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.shiftCnt  = 8'd1;
    bus.numRounds = 16'd9;
    bus.chainMask = ~m;
    for (int c = 1; c <= ncyc; c++) begin
      ph = phase_of(c, s, r);
      chk($sformatf("vec s%0d r%0d c%0d", sh, r, c), 32'(obs_vec()), 32'(exp_vec(ph, m)));
      if (ph == 2 || ph == 3) chk($sformatf("roundIdx c%0d", c), 32'(bus.roundIdx), 32'((c - 2) / (s + 1)));
      if (ph == 0 || ph == 1) chk($sformatf("roundIdx0 c%0d", c), 32'(bus.roundIdx), 32'd0);
      prpg_cnt += int'(bus.PRPG_En);
      misr_cnt += int'(bus.MISR_En);
      if (bus.PRPG_En) caps.push_back(c);
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      for (int i = 0; i < 4; i++) begin
        sisa_cnt[i] += int'(bus.SISA_En[i]);
        srsg_cnt[i] += int'(bus.SRSG_En[i]);
      end
      if (c == extra_c) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
  endtask

  initial begin
    int busy_seen;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.shiftCnt = 8'd0;
    bus.numRounds = 16'd0;
    bus.chainMask = 4'b0000;
`ifdef RTS_SIG_COMPARE_EN
    bus.sigIn = 16'h0000;
    bus.goldenSig = 16'h0000;
`endif
    repeat (3) tick();
    chk("reset vec", 32'(obs_vec()), 32'd0);
    chk("reset roundIdx", 32'(bus.roundIdx), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle vec", 32'(obs_vec()), 32'd0);

    // Full-mask baseline: S=5, R=3.
    run(5, 3, 4'b1111, 0);
    chk("caps count", 32'(caps.size()), 32'd3);
    chk("cap0", 32'(caps[0]), 32'd7);
    chk("cap1", 32'(caps[1]), 32'd13);
    chk("cap2", 32'(caps[2]), 32'd19);
    chk("done cycle 5x3", 32'(done_cyc), 32'd25);
    chk("done pulses 5x3", 32'(done_cnt), 32'd1);
    chk("prpg count", 32'(prpg_cnt), 32'd3);
    chk("misr count", 32'(misr_cnt), 32'd3);
    chk("sisa chain0", 32'(sisa_cnt[0]), 32'd20);
    chk("sisa chain3", 32'(sisa_cnt[3]), 32'd20);
    chk("srsg chain0", 32'(srsg_cnt[0]), 32'd15);

    // Sparse mask: S=2, R=2.
    run(2, 2, 4'b0101, 0);
    chk("mask done", 32'(done_cyc), 32'd10);
    chk("mask sisa1", 32'(sisa_cnt[1]), 32'd0);
    chk("mask sisa3", 32'(sisa_cnt[3]), 32'd0);
    chk("mask sisa0", 32'(sisa_cnt[0]), 32'd6);
    chk("mask srsg2", 32'(srsg_cnt[2]), 32'd4);

    // Zero rounds, then zero shift count.
    run(5, 0, 4'b1111, 0);
    chk("r0 done", 32'(done_cyc), 32'd2);
    chk("r0 prpg", 32'(prpg_cnt), 32'd0);
    chk("r0 misr", 32'(misr_cnt), 32'd0);
    run(0, 1, 4'b1111, 0);
    chk("s0 done", 32'(done_cyc), 32'd5);

    // Empty mask keeps timing.
    run(3, 2, 4'b0000, 0);
    chk("nomask done", 32'(done_cyc), 32'd13);

    // Start re-pulsed while busy is ignored.
    run(3, 2, 4'b1111, 4);
    chk("restart-busy done", 32'(done_cyc), 32'd13);
    chk("restart-busy pulses", 32'(done_cnt), 32'd1);

    // Reset in the middle of a long session.
    bus.shiftCnt = 8'd5;
    bus.numRounds = 16'd200;
    bus.chainMask = 4'b1111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("long vec c%0d", c), 32'(obs_vec()), 32'(exp_vec(phase_of(c, 5, 200), 4'b1111)));
      if (c < 10) tick();
    end
    rst = 1'b1;
    tick();
    chk("rst vec c11", 32'(obs_vec()), 32'd0);
    chk("rst roundIdx c11", 32'(bus.roundIdx), 32'd0);
    rst = 1'b0;
    done_cnt = 0;
    busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      done_cnt += int'(bus.done);
      busy_seen += int'(bus.busy);
      tick();
    end
    chk("no done after rst", 32'(done_cnt), 32'd0);
    chk("no busy after rst", 32'(busy_seen), 32'd0);
    run(5, 4, 4'b1010, 0);
    chk("post-rst done", 32'(done_cyc), 32'd31);

`ifdef RTS_SIG_COMPARE_EN
    bus.sigIn = 16'hA5A5;
    bus.goldenSig = 16'hA5A5;
    run(2, 1, 4'b0001, 0);
    chk("match pass", 32'(bus.pass), 32'd1);
    chk("match fail", 32'(bus.fail), 32'd0);
    repeat (5) tick();
    chk("match pass held", 32'(bus.pass), 32'd1);
    bus.sigIn = 16'hA5A4;
    run(2, 1, 4'b0001, 0);
    chk("miss pass", 32'(bus.pass), 32'd0);
    chk("miss fail", 32'(bus.fail), 32'd1);
    bus.shiftCnt = 8'd2;
    bus.numRounds = 16'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start clears fail", 32'(bus.fail), 32'd0);
    chk("start clears pass", 32'(bus.pass), 32'd0);
    repeat (12) tick();
    chk("second miss fail", 32'(bus.fail), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
